// File: rtl/vector_fp_multiplier.sv
// 32-element IEEE-754 single-precision vector multiplier.
// 96-word register file with a 3-stage multiply pipeline.
module vector_fp_multiplier (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic full
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  logic [31:0] reg_file [0:95];
  logic        flag6    [0:95];

  state_t r_state;
  state_t w_next;
  logic [4:0] r_idx;
  logic w_issue;

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [7:0] w_ea;
  logic [7:0] w_eb;
  logic w_anan;
  logic w_bnan;
  logic w_ainf;
  logic w_binf;
  logic w_azero;
  logic w_bzero;
  logic w_sgn;
  logic w_spec;
  logic [31:0] w_sres;
  logic w_sflag;

  logic r_s1_v;
  logic [4:0] r_s1_idx;
  logic r_s1_sgn;
  logic [7:0] r_s1_ea;
  logic [7:0] r_s1_eb;
  logic [23:0] r_s1_ma;
  logic [23:0] r_s1_mb;
  logic r_s1_spec;
  logic [31:0] r_s1_sres;
  logic r_s1_sflag;

  logic r_s2_v;
  logic [4:0] r_s2_idx;
  logic r_s2_sgn;
  logic [47:0] r_s2_prod;
  logic [9:0] r_s2_exp;
  logic r_s2_spec;
  logic [31:0] r_s2_sres;
  logic r_s2_sflag;

  logic r_s3_v;
  logic [4:0] r_s3_idx;
  logic [31:0] r_s3_res;
  logic r_s3_flag;

  logic signed [9:0] w_e3;
  logic [22:0] w_frac;
  logic [31:0] w_res;
  logic w_flag;
  logic w_unused;

  assign full = (r_state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue && r_idx != 5'd31)
        r_idx <= r_idx + 5'd1;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_issue = 1'b1;
          w_next  = S_RUN;
        end
      end
      S_RUN: begin
        if (start) begin
          w_issue = 1'b1;
          if (r_idx == 5'd31)
            w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!(r_s1_v || r_s2_v || r_s3_v))
          w_next = S_DONE;
      end
      S_DONE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_a     = reg_file[{2'b00, r_idx}];
  assign w_b     = reg_file[{2'b01, r_idx}];
  assign w_ea    = w_a[30:23];
  assign w_eb    = w_b[30:23];
  assign w_sgn   = w_a[31] ^ w_b[31];
  assign w_anan  = (w_ea == 8'hFF) && (w_a[22:0] != '0);
  assign w_bnan  = (w_eb == 8'hFF) && (w_b[22:0] != '0);
  assign w_ainf  = (w_ea == 8'hFF) && (w_a[22:0] == '0);
  assign w_binf  = (w_eb == 8'hFF) && (w_b[22:0] == '0);
  assign w_azero = (w_ea == 8'h00);
  assign w_bzero = (w_eb == 8'h00);

  // Order matters: NaN beats inf*0, which beats inf, which beats zero.
  always_comb begin
    w_spec  = 1'b1;
    w_sres  = 32'h7FC0_0000;
    w_sflag = 1'b1;
    priority case (1'b1)
      w_anan || w_bnan: ;
      (w_ainf && w_bzero) || (w_binf && w_azero): ;
      w_ainf || w_binf: w_sres = {w_sgn, 8'hFF, 23'd0};
      w_azero || w_bzero: begin
        w_sres  = {w_sgn, 31'd0};
        w_sflag = 1'b0;
      end
      default: begin
        w_spec  = 1'b0;
        w_sres  = '0;
        w_sflag = 1'b0;
      end
    endcase
  end

  assign w_e3 = r_s2_prod[47] ? $signed(r_s2_exp) + 10'sd1
                              : $signed(r_s2_exp);
  assign w_frac = r_s2_prod[47] ? r_s2_prod[46:24]
                                : r_s2_prod[45:23];

  always_comb begin
    w_res  = {r_s2_sgn, w_e3[7:0], w_frac};
    w_flag = 1'b0;
    priority case (1'b1)
      r_s2_spec: begin
        w_res  = r_s2_sres;
        w_flag = r_s2_sflag;
      end
      w_e3 >= 10'sd255: begin
        w_res  = {r_s2_sgn, 8'hFF, 23'd0};
        w_flag = 1'b1;
      end
      w_e3 <= 10'sd0: begin
        w_res  = {r_s2_sgn, 31'd0};
        w_flag = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_s3_v <= 1'b0;
      r_s1_idx <= '0;
      r_s1_sgn <= 1'b0;
      r_s1_ea <= '0;
      r_s1_eb <= '0;
      r_s1_ma <= '0;
      r_s1_mb <= '0;
      r_s1_spec <= 1'b0;
      r_s1_sres <= '0;
      r_s1_sflag <= 1'b0;
      r_s2_idx <= '0;
      r_s2_sgn <= 1'b0;
      r_s2_prod <= '0;
      r_s2_exp <= '0;
      r_s2_spec <= 1'b0;
      r_s2_sres <= '0;
      r_s2_sflag <= 1'b0;
      r_s3_idx <= '0;
      r_s3_res <= '0;
      r_s3_flag <= 1'b0;
      for (int i = 0; i < 96; i++)
        flag6[i] <= 1'b0;
    end else begin
      r_s1_v <= w_issue;
      r_s1_idx <= r_idx;
      r_s1_sgn <= w_sgn;
      r_s1_ea <= w_ea;
      r_s1_eb <= w_eb;
      r_s1_ma <= {1'b1, w_a[22:0]};
      r_s1_mb <= {1'b1, w_b[22:0]};
      r_s1_spec <= w_spec;
      r_s1_sres <= w_sres;
      r_s1_sflag <= w_sflag;
      r_s2_v <= r_s1_v;
      r_s2_idx <= r_s1_idx;
      r_s2_sgn <= r_s1_sgn;
      r_s2_prod <= {24'd0, r_s1_ma} * {24'd0, r_s1_mb};
      r_s2_exp <= {2'b00, r_s1_ea} + {2'b00, r_s1_eb} - 10'd127;
      r_s2_spec <= r_s1_spec;
      r_s2_sres <= r_s1_sres;
      r_s2_sflag <= r_s1_sflag;
      r_s3_v <= r_s2_v;
      r_s3_idx <= r_s2_idx;
      r_s3_res <= w_res;
      r_s3_flag <= w_flag;
      if (r_s3_v)
        flag6[{2'b10, r_s3_idx}] <= r_s3_flag;
    end
  end

  // Operands are preloaded externally, so the file has no reset.
  always_ff @(posedge clk) begin
    if (r_s3_v)
      reg_file[{2'b10, r_s3_idx}] <= r_s3_res;
  end

  always_comb begin
    w_unused = ^r_s2_prod[22:0];
    for (int i = 0; i < 96; i++)
      w_unused = w_unused ^ flag6[i];
  end

endmodule

// File: tb/tb_vector_fp_multiplier.sv
// Randomized scoreboard bench for vector_fp_multiplier.
// Expected products come from an arithmetic reference model.
module tb_vector_fp_multiplier;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic full;

  vector_fp_multiplier dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .full(full)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] res;
    logic        flg;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] opa [32];
  logic [31:0] opb [32];
  logic [31:0] eres [32];
  logic        eflg [32];

  task automatic chk(input string nm, input int n,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, n, act, want);
    end
  endtask

  function automatic logic [32:0] fmul_ref(input logic [31:0] a,
                                           input logic [31:0] b);
    logic s;
    int ea, eb, e;
    longint fa, fb, p;
    logic [22:0] fr;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0))
      return {1'b1, 32'h7FC0_0000};
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0))
      return {1'b1, 32'h7FC0_0000};
    if (ea == 255 || eb == 255)
      return {1'b1, s, 8'hFF, 23'd0};
    if (ea == 0 || eb == 0)
      return {1'b0, s, 31'd0};
    p = (fa + 64'h80_0000) * (fb + 64'h80_0000);
    e = ea + eb - 127;
    if (p >= (longint'(1) << 47)) begin
      p = p / 2;
      e = e + 1;
    end
    fr = 23'((p / 64'h80_0000) % 64'h80_0000);
    if (e >= 255)
      return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0)
      return {1'b1, s, 31'd0};
    return {1'b0, s, 8'(e), fr};
  endfunction

  function automatic logic [31:0] rnd_normal();
    logic [7:0] e;
    e = 8'($urandom_range(190, 64));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic load_ops();
    logic [32:0] r;
    for (int n = 0; n < 32; n++) begin
      dut.reg_file[n] = opa[n];
      dut.reg_file[32 + n] = opb[n];
      r = fmul_ref(opa[n], opb[n]);
      eres[n] = r[31:0];
      eflg[n] = r[32];
    end
  endtask

  task automatic push_exp();
    for (int n = 0; n < 32; n++)
      q.push_back({5'(n), eres[n], eflg[n]});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_job(input int pa, input int pl, output int fe);
    fe = -1;
    for (int k = 1; k <= 80; k++) begin
      start = (k > pa && k <= pa + pl) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (full && fe < 0)
        fe = k;
      if (fe > 0)
        break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_flags_clear(input string nm);
    int c = 0;
    for (int i = 0; i < 96; i++)
      if (dut.flag6[i] !== 1'b0)
        c++;
    chk(nm, 0, 32'(c), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge full);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("res", int'(e.idx),
            dut.reg_file[64 + int'(e.idx)], e.res);
        chk("flag", int'(e.idx),
            {31'd0, dut.flag6[64 + int'(e.idx)]},
            {31'd0, e.flg});
      end
    end
  end

  localparam logic [31:0] SA [9] = '{
    32'h3FC0_0000, 32'hBF80_0000, 32'h0000_0000,
    32'h7F80_0000, 32'h7F00_0000, 32'h0080_0000,
    32'h7FC1_2345, 32'hFF80_0000, 32'h8000_0001};
  localparam logic [31:0] SB [9] = '{
    32'h4000_0000, 32'h40A0_0000, 32'h42F6_0000,
    32'h0000_0000, 32'h7F00_0000, 32'h0080_0000,
    32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000};
  localparam logic [31:0] SR [9] = '{
    32'h4040_0000, 32'hC0A0_0000, 32'h0000_0000,
    32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000,
    32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000};
  localparam logic SF [9] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin : driver
    int fe;
    int c;
    logic [31:0] snap [32];

    repeat (3) @(negedge clk);
    chk("rst_full", 0, {31'd0, full}, 32'd0);
    chk_flags_clear("rst_flag6");
    reset = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 32; n++) begin
      opa[n] = rnd_normal();
      opb[n] = rnd_normal();
    end
    load_ops();
    push_exp();
    run_job(0, 0, fe);
    chk("full_edge_job1", 0, 32'(fe), 32'd36);

    pulse_reset();
    chk("full_after_rst", 0, {31'd0, full}, 32'd0);
    for (int n = 0; n < 32; n++) begin
      opa[n] = $urandom;
      opb[n] = $urandom;
    end
    for (int n = 0; n < 9; n++) begin
      opa[n] = SA[n];
      opb[n] = SB[n];
    end
    load_ops();
    for (int n = 0; n < 9; n++) begin
      eres[n] = SR[n];
      eflg[n] = SF[n];
    end
    push_exp();
    run_job(0, 0, fe);
    chk("full_edge_job2", 0, 32'(fe), 32'd36);

    pulse_reset();
    chk_flags_clear("flag6_after_rst");
    for (int n = 0; n < 32; n++) begin
      opa[n] = rnd_normal();
      opb[n] = rnd_normal();
    end
    load_ops();
    push_exp();
    run_job(12, 5, fe);
    chk("full_edge_pause", 0, 32'(fe), 32'd41);

    pulse_reset();
    for (int n = 0; n < 32; n++) begin
      opa[n] = rnd_normal();
      opb[n] = rnd_normal();
      dut.reg_file[64 + n] = 32'd0;
    end
    load_ops();
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      if (k < 10)
        @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    #1;
    chk("abort_full", 0, {31'd0, full}, 32'd0);
    for (int n = 0; n < 32; n++)
      chk("abort_keep", n, dut.reg_file[64 + n],
          (n < 7) ? eres[n] : 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push_exp();
    run_job(0, 0, fe);
    chk("full_edge_rerun", 0, 32'(fe), 32'd36);
    c = 0;
    for (int n = 0; n < 32; n++)
      if (dut.reg_file[n] !== opa[n] ||
          dut.reg_file[32 + n] !== opb[n])
        c++;
    chk("operands_kept", 0, 32'(c), 32'd0);

    for (int n = 0; n < 32; n++)
      snap[n] = dut.reg_file[64 + n];
    c = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start = k[0];
      @(posedge clk);
      #1;
      if (full !== 1'b1)
        c++;
    end
    chk("done_hold", 0, 32'(c), 32'd0);
    c = 0;
    for (int n = 0; n < 32; n++)
      if (dut.reg_file[64 + n] !== snap[n])
        c++;
    chk("done_nowrite", 0, 32'(c), 32'd0);

    pulse_reset();
    @(posedge clk);
    #1;
    chk("final_rst_full", 0, {31'd0, full}, 32'd0);
    chk("queue_empty", 0, 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
